// File: rtl/dff_pipe.sv
// Elastic register pipeline: DEPTH valid/ready stages carrying a WIDTH-bit word, with flush.
// Optional occupancy counter enabled by defining DFF_PIPE_OCC_EN; otherwise occ is tied to 0.
module dff_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(DEPTH+1)-1:0]   occ
);

  localparam int unsigned OccW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [DEPTH-1:0] rdy;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];

  // Stage i may advance if out_ready or any stage at or beyond i is empty (unrolled ready chain).
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      rdy[i] = out_ready;
      for (int unsigned j = i; j < DEPTH; j++) begin
        if (!vld_q[j]) rdy[i] = 1'b1;
      end
    end
  end

  assign in_ready  = rdy[0] & ~flush;
  assign out_valid = vld_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (rdy[0]) begin
      vld_d[0]  = in_valid & ~flush;
      data_d[0] = in_data;
    end
    for (int unsigned i = 1; i < DEPTH; i++) begin
      if (rdy[i]) begin
        vld_d[i]  = vld_q[i-1];
        data_d[i] = data_q[i-1];
      end
    end
    if (flush) vld_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) data_q[i] <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

`ifdef DFF_PIPE_OCC_EN
  logic [OccW-1:0] occ_q, occ_d;
  logic            accept, deliver;

  assign accept  = in_valid & in_ready;
  assign deliver = out_valid & out_ready;

  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (accept && !deliver && occ_q != OccW'(DEPTH)) begin
      occ_d = occ_q + 1'b1;
    end else if (deliver && !accept && occ_q != '0) begin
      occ_d = occ_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) occ_q <= '0;
    else     occ_q <= occ_d;
  end

  assign occ = occ_q;
`else
  assign occ = '0;
`endif

endmodule

// File: tb/tb_dff_pipe.sv
// Bench for dff_pipe: directed scenarios plus a randomized run against a queue-based model.
module tb_dff_pipe;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 3;
  localparam int unsigned OW    = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready, out_valid;
  logic [WIDTH-1:0] out_data;
  logic [OW-1:0]    occ;
  logic             d1_in_ready, d1_out_valid;
  logic [WIDTH-1:0] d1_out_data;
  logic [0:0]       d1_occ;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [WIDTH-1:0] exp_q[$];
  int               acc_q[$];

  dff_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occ(occ)
  );

  dff_pipe #(.WIDTH(WIDTH), .DEPTH(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(d1_in_ready),
    .in_data(in_data), .out_valid(d1_out_valid), .out_ready(out_ready),
    .out_data(d1_out_data), .occ(d1_occ)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [OW-1:0] occ_ref(input int n);
`ifdef DFF_PIPE_OCC_EN
    return OW'(n);
`else
    return OW'(0 * n);
`endif
  endfunction

  function automatic logic exp_in_ready();
    return !flush && ((exp_q.size() < DEPTH) || out_ready);
  endfunction

  // Apply inputs mid-cycle, then settle so combinational outputs can be sampled.
  task automatic drive(input logic r, input logic v, input logic [WIDTH-1:0] d,
                       input logic o, input logic f);
    @(negedge clk);
    rst = r; in_valid = v; in_data = d; out_ready = o; flush = f;
    #1;
  endtask

  // Advance the reference model by this cycle's handshakes (no comparisons here).
  task automatic commit();
    if (rst) begin
      exp_q.delete(); acc_q.delete();
    end else begin
      if (out_valid && out_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front()); void'(acc_q.pop_front());
      end
      if (flush) begin
        exp_q.delete(); acc_q.delete();
      end else if (in_valid && in_ready) begin
        exp_q.push_back(in_data); acc_q.push_back(cyc);
      end
    end
  endtask

  task automatic test_reset();
    drive(1, 0, 8'h00, 0, 0); commit();
    drive(1, 1, 8'h5A, 1, 0); commit();
    drive(0, 0, 8'h00, 0, 0);
    checks++; if (out_valid !== 1'b0) begin failures++;
      $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin failures++;
      $display("FAIL reset_out_data: got %h expected 00", out_data); end
    checks++; if (occ !== occ_ref(0)) begin failures++;
      $display("FAIL reset_occ: got %0d expected %0d", occ, occ_ref(0)); end
    checks++; if (in_ready !== 1'b1) begin failures++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (d1_out_valid !== 1'b0 || d1_in_ready !== 1'b1) begin failures++;
      $display("FAIL reset_d1: got valid=%b ready=%b expected 0/1", d1_out_valid, d1_in_ready);
    end
    commit();
  endtask

  task automatic test_stream();
    logic [WIDTH-1:0] w [3];
    logic             ev;
    logic [WIDTH-1:0] ed;
    w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33;
    for (int k = 0; k < 8; k++) begin
      drive(0, k < 3, (k < 3) ? w[k % 3] : 8'h00, 1, 0);
      checks++; if (in_ready !== 1'b1) begin failures++;
        $display("FAIL stream_in_ready c%0d: got %b expected 1", k, in_ready); end
      ev = (k >= 3 && k <= 5);
      ed = ev ? w[(k - 3) % 3] : 8'h00;
      checks++; if (out_valid !== ev || (ev && out_data !== ed)) begin failures++;
        $display("FAIL stream_out c%0d: got v=%b d=%h expected v=%b d=%h",
                 k, out_valid, out_data, ev, ed); end
      ev = (k >= 1 && k <= 3);
      ed = ev ? w[(k - 1) % 3] : 8'h00;
      checks++; if (d1_out_valid !== ev || (ev && d1_out_data !== ed)) begin failures++;
        $display("FAIL stream_d1_out c%0d: got v=%b d=%h expected v=%b d=%h",
                 k, d1_out_valid, d1_out_data, ev, ed); end
      commit();
    end
  endtask

  task automatic test_stall();
    int idx = 0;
    for (int k = 0; k < 11; k++) begin
      drive(0, idx < 5, 8'(idx + 1), k >= 6, 0);
      if (k < 6) begin
        checks++; if (in_ready !== (k < 3)) begin failures++;
          $display("FAIL stall_in_ready c%0d: got %b expected %b", k, in_ready, k < 3); end
        checks++; if (occ !== occ_ref(k < 3 ? k : 3)) begin failures++;
          $display("FAIL stall_occ c%0d: got %0d expected %0d", k, occ, occ_ref(k < 3 ? k : 3));
        end
        if (k >= 3) begin
          checks++; if (out_valid !== 1'b1 || out_data !== 8'h01) begin failures++;
            $display("FAIL stall_hold c%0d: got v=%b d=%h expected 1/01", k, out_valid, out_data);
          end
        end
      end else begin
        checks++; if (out_valid !== 1'b1 || out_data !== 8'(k - 5)) begin failures++;
          $display("FAIL stall_drain c%0d: got v=%b d=%h expected 1/%h",
                   k, out_valid, out_data, 8'(k - 5)); end
      end
      if (in_valid && in_ready) idx++;
      commit();
    end
  endtask

  task automatic test_full_swap();
    logic [WIDTH-1:0] seq [7];
    seq[0] = 8'hA0; seq[1] = 8'hA1; seq[2] = 8'hA2;
    seq[3] = 8'hB0; seq[4] = 8'hB1; seq[5] = 8'hB2; seq[6] = 8'hB3;
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, seq[k], 0, 0); commit();
    end
    drive(0, 0, 8'h00, 0, 0);
    checks++; if (in_ready !== 1'b0) begin failures++;
      $display("FAIL full_in_ready: got %b expected 0", in_ready); end
    commit();
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, seq[3 + k], 1, 0);
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== seq[k]) begin
        failures++;
        $display("FAIL swap c%0d: got r=%b v=%b d=%h expected 1/1/%h",
                 k, in_ready, out_valid, out_data, seq[k]); end
      checks++; if (occ !== occ_ref(3)) begin failures++;
        $display("FAIL swap_occ c%0d: got %0d expected %0d", k, occ, occ_ref(3)); end
      commit();
    end
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 8'h00, 1, 0);
      checks++;
      if (out_valid !== (k < 3) || (k < 3 && out_data !== seq[4 + (k % 3)])) begin failures++;
        $display("FAIL swap_drain c%0d: got v=%b d=%h expected v=%b d=%h",
                 k, out_valid, out_data, k < 3, seq[4 + (k % 3)]); end
      commit();
    end
  endtask

  task automatic test_flush();
    drive(0, 1, 8'h31, 0, 0); commit();
    drive(0, 1, 8'h32, 0, 0); commit();
    drive(0, 1, 8'hAA, 0, 1);
    checks++; if (in_ready !== 1'b0) begin failures++;
      $display("FAIL flush_in_ready: got %b expected 0", in_ready); end
    commit();
    for (int k = 0; k < DEPTH + 2; k++) begin
      drive(0, 0, 8'h00, 1, 0);
      checks++; if (out_valid !== 1'b0) begin failures++;
        $display("FAIL flush_out_valid c%0d: got %b d=%h expected 0", k, out_valid, out_data);
      end
      checks++; if (occ !== occ_ref(0)) begin failures++;
        $display("FAIL flush_occ c%0d: got %0d expected %0d", k, occ, occ_ref(0)); end
      commit();
    end
  endtask

  task automatic test_random();
    logic             prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_data = '0;
    int               guard;
    for (int k = 0; k < 10000; k++) begin
      drive(0, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
            $urandom_range(0, 63) == 0);
      checks++; if (in_ready !== exp_in_ready()) begin failures++;
        $display("FAIL rand_in_ready c%0d: got %b expected %b", k, in_ready, exp_in_ready());
      end
      checks++; if (occ !== occ_ref(exp_q.size())) begin failures++;
        $display("FAIL rand_occ c%0d: got %0d expected %0d", k, occ, occ_ref(exp_q.size()));
      end
      if (out_valid === 1'b1) begin
        checks++; if (exp_q.size() == 0 || out_data !== exp_q[0]) begin failures++;
          $display("FAIL rand_order c%0d: got %h expected %h", k, out_data,
                   exp_q.size() ? exp_q[0] : 8'hxx); end
        if (out_ready && exp_q.size() > 0) begin
          checks++; if (cyc < acc_q[0] + int'(DEPTH)) begin failures++;
            $display("FAIL rand_latency c%0d: got cycle %0d expected >= %0d",
                     k, cyc, acc_q[0] + int'(DEPTH)); end
        end
      end
      if (prev_stall) begin
        checks++; if (out_valid !== 1'b1 || out_data !== prev_data) begin failures++;
          $display("FAIL rand_stable c%0d: got v=%b d=%h expected 1/%h",
                   k, out_valid, out_data, prev_data); end
      end
      prev_stall = out_valid && !out_ready && !flush;
      prev_data  = out_data;
      commit();
    end
    guard = 0;
    while (exp_q.size() > 0 && guard < 4 * DEPTH + 4) begin
      drive(0, 0, 8'h00, 1, 0);
      checks++; if (out_valid === 1'b1 && out_data !== exp_q[0]) begin failures++;
        $display("FAIL rand_drain_order: got %h expected %h", out_data, exp_q[0]); end
      commit();
      guard++;
    end
    checks++; if (exp_q.size() != 0) begin failures++;
      $display("FAIL rand_drain: got %0d words left expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    drive(0, 1, 8'h71, 0, 0); commit();
    drive(0, 1, 8'h72, 0, 0); commit();
    drive(0, 0, 8'h00, 0, 0);
    checks++; if (occ !== occ_ref(2)) begin failures++;
      $display("FAIL rmid_occ_pre: got %0d expected %0d", occ, occ_ref(2)); end
    commit();
    drive(1, 1, 8'h73, 0, 0); commit();
    drive(0, 0, 8'h00, 1, 0);
    checks++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin failures++;
      $display("FAIL rmid_out: got v=%b d=%h expected 0/00", out_valid, out_data); end
    checks++; if (occ !== occ_ref(0) || in_ready !== 1'b1) begin failures++;
      $display("FAIL rmid_state: got occ=%0d r=%b expected %0d/1", occ, in_ready, occ_ref(0));
    end
    commit();
    for (int k = 0; k < DEPTH + 1; k++) begin
      drive(0, 0, 8'h00, 1, 0);
      checks++; if (out_valid !== 1'b0) begin failures++;
        $display("FAIL rmid_stale c%0d: got %b d=%h expected 0", k, out_valid, out_data); end
      commit();
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_full_swap();
    test_flush();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
